// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Definitions shared by the parity generator and the parity_rx_checker:
//   DATA_W_DEF  : default data word width (64 bits)
//   err_state_e : two-state sticky error tracker (CLEAN / ERR)
//   parity_of() : even parity of a DATA_W_DEF-bit word (XOR reduction)
// -----------------------------------------------------------------------------
package parity_pkg;

   localparam int DATA_W_DEF = 64;

   typedef enum logic {
      CLEAN = 1'b0,
      ERR   = 1'b1
   } err_state_e;

   // The generator drives this value as its parity bit, so the receiver
   // recomputing it and XORing with the received bit yields 0 on a good word.
   function automatic logic parity_of(input logic [DATA_W_DEF-1:0] data);
      return ^data;
   endfunction

endpackage : parity_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a synchronous clear that takes effect before the
// increment of the same cycle (clr_i && inc_i leaves the counter at 1).
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, counter -> 0
//   inc_i  in   count one event this cycle
//   clr_i  in   synchronous clear
//   cnt_o  out  CNT_W-bit count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_base;

   // Clear is applied first, then the increment is added on top of the
   // (possibly cleared) value.
   always_comb begin
      // NOTE: every signal written here is assigned a default up front so no
      // path through the block leaves it unassigned (no inferred latch).
      cnt_base = clr_i ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (inc_i && (cnt_base != {CNT_W{1'b1}})) begin
         cnt_d = cnt_base + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/parity_rx_checker.sv
// -----------------------------------------------------------------------------
// parity_rx_checker
// Receive-side parity checker. Accepts {data, parity} words over valid/ready,
// re-registers each word together with its parity-error flag (one stage of
// latency, full throughput), and keeps a sticky error flag plus a saturating
// count of erroneous words for status readout.
//
// Parameters:
//   DATA_W  data word width
//   ODD     parity sense: 0 = even, 1 = odd
//   CNT_W   error counter width
//
// Ports:
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   in_valid/ready    input handshake; in_ready = !out_valid || out_ready
//   in_data/parity    received word and its parity bit
//   out_valid/ready   output handshake
//   out_data/err      registered word and its parity-error flag
//   err_sticky        set by any accepted erroneous word, cleared by err_clr
//   err_cnt           saturating count of accepted erroneous words
//   err_clr           synchronous clear of err_sticky / err_cnt
//
// Build option:
//   PARITY_RX_CAPTURE_EN  adds first_err_data / first_err_valid, holding the
//                         first erroneous word since reset or err_clr.
// -----------------------------------------------------------------------------
module parity_rx_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter bit ODD    = 1'b0,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_cnt,
`ifdef PARITY_RX_CAPTURE_EN
   output logic [DATA_W-1:0] first_err_data,
   output logic              first_err_valid,
`endif
   input  logic              err_clr
);

   // ---------------------------------------------------------------------------
   // Parity check of the incoming word
   // ---------------------------------------------------------------------------
   logic data_par;
   logic word_err;

   // The shared helper is sized for the default width; other widths reduce
   // the bus directly, which is the same function.
   if (DATA_W == DATA_W_DEF) begin : g_par_pkg
      assign data_par = parity_of(in_data);
   end else begin : g_par_direct
      assign data_par = ^in_data;
   end

   assign word_err = data_par ^ in_parity ^ ODD;

   // ---------------------------------------------------------------------------
   // Handshake and output register
   // ---------------------------------------------------------------------------
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_err_q,   out_err_d;
   logic              accept;
   logic              err_accept;

   // No skid buffer: the slot is free when empty or being drained this cycle.
   assign in_ready   = !out_valid_q || out_ready;
   assign accept     = in_valid && in_ready;
   assign err_accept = accept && word_err;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (accept) begin
         // Covers both the empty case and drain+accept (no bubble).
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_err_d   = word_err;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

   // ---------------------------------------------------------------------------
   // Sticky error state. Errors are taken at accept time, so a word that sits
   // in the output register under backpressure is counted exactly once.
   // ---------------------------------------------------------------------------
   err_state_e err_state_q, err_state_d;

   always_comb begin
      err_state_d = err_state_q;
      if (err_clr) begin
         // Clear first; an error accepted in the same cycle re-arms the flag.
         err_state_d = err_accept ? ERR : CLEAN;
      end else if (err_accept) begin
         err_state_d = ERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_state_q <= CLEAN;
      end else begin
         err_state_q <= err_state_d;
      end
   end

   assign err_sticky = (err_state_q == ERR);

   // ---------------------------------------------------------------------------
   // Error counter
   // ---------------------------------------------------------------------------
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_accept),
      .clr_i (err_clr),
      .cnt_o (err_cnt)
   );

`ifdef PARITY_RX_CAPTURE_EN
   // ---------------------------------------------------------------------------
   // First-error capture: armed after reset or err_clr, frozen by the first
   // erroneous word until the next clear.
   // ---------------------------------------------------------------------------
   logic              cap_valid_q, cap_valid_d;
   logic [DATA_W-1:0] cap_data_q,  cap_data_d;
   logic              cap_armed;

   assign cap_armed = err_clr || !cap_valid_q;

   always_comb begin
      cap_valid_d = cap_valid_q;
      cap_data_d  = cap_data_q;
      if (err_clr) begin
         cap_valid_d = 1'b0;
         cap_data_d  = '0;
      end
      if (err_accept && cap_armed) begin
         cap_valid_d = 1'b1;
         cap_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid_q <= 1'b0;
         cap_data_q  <= '0;
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_data_q  <= cap_data_d;
      end
   end

   assign first_err_valid = cap_valid_q;
   assign first_err_data  = cap_data_q;
`endif

endmodule : parity_rx_checker

// File: tb/tb_parity_rx_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_rx_checker
// Directed bench for parity_rx_checker (DATA_W=64, ODD=0, CNT_W=4). Accepted
// words are pushed to a scoreboard queue and compared when they appear at the
// output; status outputs are compared against a small reference model.
// -----------------------------------------------------------------------------
module tb_parity_rx_checker;

   localparam int      DW      = 64;
   localparam int      CW      = 4;
   localparam bit      ODDP    = 1'b0;
   localparam int      CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_parity;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_err;
   logic          err_sticky;
   logic [CW-1:0] err_cnt;
   logic          err_clr;
`ifdef PARITY_RX_CAPTURE_EN
   logic [DW-1:0] first_err_data;
   logic          first_err_valid;
`endif

   always #5 clk = ~clk;

   parity_rx_checker #(
      .DATA_W (DW),
      .ODD    (ODDP),
      .CNT_W  (CW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_parity       (in_parity),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_err         (out_err),
      .err_sticky      (err_sticky),
      .err_cnt         (err_cnt),
`ifdef PARITY_RX_CAPTURE_EN
      .first_err_data  (first_err_data),
      .first_err_valid (first_err_valid),
`endif
      .err_clr         (err_clr)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   int            m_cnt;
   logic          m_sticky;
   logic          m_cap_valid;
   logic [DW-1:0] m_cap_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Parity error as seen by the receiver for the bench's parity sense.
   function automatic logic model_err(input logic [DW-1:0] d, input logic p);
      logic acc;
      acc = p ^ ODDP;
      for (int i = 0; i < DW; i++) acc = acc ^ d[i];
      return acc;
   endfunction

   function automatic logic good_par(input logic [DW-1:0] d);
      logic acc;
      acc = ODDP;
      for (int i = 0; i < DW; i++) acc = acc ^ d[i];
      return acc;
   endfunction

   task automatic check_status(input string tag);
      check({tag, ":err_cnt"}, 64'(err_cnt), 64'(m_cnt));
      check({tag, ":err_sticky"}, 64'(err_sticky), 64'(m_sticky));
`ifdef PARITY_RX_CAPTURE_EN
      check({tag, ":first_err_valid"}, 64'(first_err_valid), 64'(m_cap_valid));
      check({tag, ":first_err_data"}, first_err_data, m_cap_data);
`endif
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ":out_valid"}, 64'(out_valid), 64'd0);
      check({tag, ":out_data"}, out_data, 64'd0);
      check({tag, ":out_err"}, 64'(out_err), 64'd0);
      check_status(tag);
   endtask

   task automatic model_reset();
      sb.delete();
      m_cnt       = 0;
      m_sticky    = 1'b0;
      m_cap_valid = 1'b0;
      m_cap_data  = '0;
   endtask

   // One clock cycle with the inputs currently applied. Called just after a
   // falling edge; returns at the next falling edge.
   task automatic tick(input string tag);
      exp_t e;
      logic exp_ready;
      logic acc;
      logic drn;
      logic bad;
      #1;
      exp_ready = (sb.size() == 0) || out_ready;
      check({tag, ":in_ready"}, 64'(in_ready), 64'(exp_ready));
      check({tag, ":out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
         check({tag, ":out_data"}, out_data, sb[0].data);
         check({tag, ":out_err"}, 64'(out_err), 64'(sb[0].err));
      end
      acc = in_valid && exp_ready;
      drn = (sb.size() != 0) && out_ready;
      bad = acc && model_err(in_data, in_parity);
      if (drn) void'(sb.pop_front());
      if (acc) begin
         e.data = in_data;
         e.err  = model_err(in_data, in_parity);
         sb.push_back(e);
      end
      if (err_clr) begin
         m_cnt       = 0;
         m_sticky    = 1'b0;
         m_cap_valid = 1'b0;
         m_cap_data  = '0;
      end
      if (bad) begin
         if (m_cnt < CNT_MAX) m_cnt++;
         m_sticky = 1'b1;
         if (!m_cap_valid) begin
            m_cap_valid = 1'b1;
            m_cap_data  = in_data;
         end
      end
      @(posedge clk);
      #1;
      check_status(tag);
      @(negedge clk);
   endtask

   task automatic drive(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic p, input logic rdy, input logic clr);
      in_valid  = v;
      in_data   = d;
      in_parity = p;
      out_ready = rdy;
      err_clr   = clr;
      tick(tag);
   endtask

   // X on in_parity with a valid word is a protocol violation.
   always @(posedge clk) begin
      if (rst_n && in_valid) begin
         n_assert++;
         assert (!$isunknown(in_parity))
         else begin
            n_fail++;
            $error("FAIL protocol: in_parity=%b while in_valid=1", in_parity);
         end
      end
   end

   initial begin
      logic [DW-1:0] d;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_parity = 1'b0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      model_reset();

      // Reset values, during and immediately after reset.
      #12;
      check_reset_values("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_values("after_release");
      @(negedge clk);

      // Clean word, then idle so it is seen and drained.
      drive("clean", 1'b1, 64'd32, 1'b1, 1'b1, 1'b0);
      drive("clean_out", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Bad words: 32 with parity 0, then all-ones with parity 1.
      drive("bad1", 1'b1, 64'd32, 1'b0, 1'b1, 1'b0);
      drive("bad2", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      drive("bad_out", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Backpressure: first bad word held, later offers refused.
      d = 64'h0000_0000_0000_00A5;
      drive("bp_acc", 1'b1, d, ~good_par(d), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         d = 64'h1234_0000_0000_0000 + 64'(i);
         drive("bp_hold", 1'b1, d, ~good_par(d), 1'b0, 1'b0);
      end

      // Release: four words back-to-back, the third one erroneous.
      for (int i = 1; i <= 4; i++) begin
         d = 64'h1111_1111_1111_1111 * 64'(i);
         drive("stream", 1'b1, d, (i == 3) ? ~good_par(d) : good_par(d), 1'b1, 1'b0);
      end
      drive("stream_out", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Clear race: build err_cnt=5, then clear together with a bad word.
      drive("clr0", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         d = 64'hDEAD_BEEF_0000_0000 | 64'(i);
         drive("to5", 1'b1, d, ~good_par(d), 1'b1, 1'b0);
      end
      d = 64'hCAFE_F00D_0000_0001;
      drive("clr_race", 1'b1, d, ~good_par(d), 1'b1, 1'b1);
      drive("clr_alone", 1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Saturation: 20 erroneous words into a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         d = {32'($urandom), 32'($urandom)};
         drive("sat", 1'b1, d, ~good_par(d), 1'b1, 1'b0);
      end
      drive("sat_out", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("sat_final", 64'(err_cnt), 64'(CNT_MAX));

      // Reset mid-operation: out_valid=1, err_cnt=3.
      drive("pre_rst_clr", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         d = 64'h0BAD_0000_0000_0000 | 64'(i);
         drive("pre_rst", 1'b1, d, ~good_par(d), 1'b1, 1'b0);
      end
      check("pre_rst:out_valid", 64'(out_valid), 64'd1);
      check("pre_rst:err_cnt", 64'(err_cnt), 64'd3);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive("post_rst", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_parity_rx_checker
